cmndf_pitch_module: RTL and testbench
=====================================

Name: cmndf_pitch_module

Overview:
Streaming YIN stage 3+4 block: consumes the difference function d(tau), tau = 0..MAX_TAU-1, one value per handshake, and computes the cumulative-mean-normalised value d'(tau) in unsigned fixed point using an internal sequential restoring divider. It runs the absolute-threshold search on the fly and reports the first local-minimum lag below THRESHOLD as the pitch period.
Sits between the bank of difference engines and the pitch/frequency back end, and replaces the batch normalisation stage. It is generalised in width, depth, fixed-point format and threshold, and adds the search.

Parameters:
DATA_WIDTH, 32, width of each unsigned d(tau) input
FRAC_BITS, 16, fractional bits of d'; ONE = 1<<FRAC_BITS
MAX_TAU, 40, number of lags per frame (tau 0..MAX_TAU-1)
TAU_BITS, 6, lag index width; 2**TAU_BITS >= MAX_TAU
MIN_TAU, 2, lowest lag eligible for pitch search
THRESHOLD, 6554, absolute threshold in d' units (0.1 at FRAC_BITS=16)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  single-cycle pulse, begins a frame (honoured only in IDLE)
in_valid  in  1  d_in valid
in_ready  out  1  block accepts d_in this cycle
d_in  in  DATA_WIDTH  d(tau), lags delivered strictly in order from 0
busy  out  1  frame in progress
done  out  1  one-cycle pulse, result valid
voiced  out  1  1 = threshold crossing found
pitch_tau  out  TAU_BITS  selected lag
pitch_val  out  FRAC_BITS+TAU_BITS  d' at pitch_tau

Behaviour:
- Reset (reset low, async): state IDLE. All outputs 0. Sum, lag counter, divider and search registers cleared. Reset mid-frame aborts the frame; no done is produced.
- Widths: SUM_W = DATA_WIDTH+TAU_BITS. Dividend = (d*tau)<<FRAC_BITS. Quotient width QW = FRAC_BITS+TAU_BITS. Because d' <= tau, no saturation is needed.
- FSM states:
  - IDLE: start -> LOAD with tau=0, sum=0, busy=1.
  - LOAD: in_ready=1. When in_valid is high:
    - tau=0: d'=ONE, go to UPDATE; sum is unchanged.
    - tau>0: sum += d_in, latch dividend, go to DIV.
  - DIV: one quotient bit per cycle, QW cycles. The divisor is the updated sum. If sum==0, d'=ONE and DIV is skipped (1 cycle).
  - UPDATE: apply the search rule, then tau++. tau==MAX_TAU-1 -> FIN, else LOAD.
  - FIN: drive outputs, pulse done for 1 cycle, busy=0, go to IDLE.
- in_ready is 0 in every state except LOAD. Per-lag cost: 1 (LOAD) + QW (DIV) + 1 (UPDATE) cycles. Defaults give 24 cycles per lag.
- Search rule (tau >= MIN_TAU only):
  - Phase SEEK: track the global minimum; strict < comparison, so the lowest tau wins ties. The first d' < THRESHOLD sets found=1, best=(tau,d'), phase TRACK.
  - Phase TRACK: if d' < best, update best. Otherwise lock the result; later lags are still consumed but ignored.
  - At FIN: if found, voiced=1 and pitch = best. If not found, voiced=0 and pitch = the global minimum.
- A frame that ends while still in TRACK reports the current best with voiced=1.
- start while busy is ignored. in_valid outside LOAD is ignored and no data is lost, because upstream holds the value until in_ready.
- pitch_tau, pitch_val and voiced hold their values until the next done or reset.

Optional Feature:
CMNDF_STREAM_EN: when defined, adds output ports cmndf_valid (1), cmndf_tau (TAU_BITS) and cmndf_out (QW). These carry a one-cycle strobe in UPDATE with each d'(tau), for tau 0..MAX_TAU-1 in order; there is no backpressure. When undefined, the ports and their registers are absent, and only the pitch result is produced.

Test Plan:
- Four equal-value frames, d(1..39)=1000 -> every d'=65536; done with voiced=0, pitch_tau=2, pitch_val=65536.
- All-zero frame -> divisor 0 on every lag, d'=ONE; done with voiced=0, pitch_tau=2, pitch_val=65536.
- Dip frame: d(1..3)=100, d(4)=1, d(5..39)=100 -> d'(4)=870, d'(5)=81715 locks. done: voiced=1, pitch_tau=4, pitch_val=870.
- Handshake timing: in_valid held high for the whole frame -> in_ready high exactly 1 cycle per lag; lags tau>=1 are spaced 24 cycles apart; done 1 cycle after UPDATE of tau=39.
- Abort and protocol:
  - Pull reset low mid-DIV at tau=10 -> outputs 0 immediately; no done; a fresh start then completes a dip frame correctly.
  - A start pulse during busy does not restart the frame.
- With CMNDF_STREAM_EN on the dip frame -> 40 cmndf_valid strobes; cmndf_out = 65536, 65536, 65536, 65536, 870, 81715, ...

Source files
------------

// File: rtl/cmndf_pitch_module.sv
// -----------------------------------------------------------------------------
// cmndf_pitch_module
//
// Streaming YIN normalisation and absolute-threshold pitch search.
// Each frame consumes d(tau) for tau = 0..MAX_TAU-1, one value per
// in_valid/in_ready handshake.
//
// For every lag the block forms the cumulative-mean-normalised value
//     d'(tau) = d(tau) * tau / sum_{j=1..tau} d(j)
// in unsigned fixed point with FRAC_BITS fractional bits.  The quotient comes
// from a sequential restoring divider that produces one bit per cycle.
// The pitch search runs on the fly.  The result is the first local minimum of
// d' that falls below THRESHOLD; if no lag crosses the threshold, it is the
// global minimum.
//
// Optional build macro: CMNDF_STREAM_EN
//   When defined, every d'(tau) is also streamed out on cmndf_valid,
//   cmndf_tau and cmndf_out, with one strobe per lag and no backpressure.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-low reset; aborts any frame
//   start        in   begins a frame; honoured only while idle
//   in_valid     in   d_in is valid
//   in_ready     out  d_in is accepted this cycle
//   d_in         in   d(tau), delivered in lag order starting at 0
//   busy         out  a frame is in progress
//   done         out  one-cycle pulse; the result outputs are valid
//   voiced       out  a threshold crossing was found
//   pitch_tau    out  selected lag
//   pitch_val    out  d' at the selected lag
//   cmndf_valid  out  (CMNDF_STREAM_EN) strobe carrying d'(tau)
//   cmndf_tau    out  (CMNDF_STREAM_EN) lag of the streamed value
//   cmndf_out    out  (CMNDF_STREAM_EN) streamed d'(tau)
// -----------------------------------------------------------------------------
module cmndf_pitch_module #(
    parameter int DATA_WIDTH = 32,
    parameter int FRAC_BITS  = 16,
    parameter int MAX_TAU    = 40,
    parameter int TAU_BITS   = 6,
    parameter int MIN_TAU    = 2,
    parameter int THRESHOLD  = 6554
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DATA_WIDTH-1:0]         d_in,
    output logic                          busy,
    output logic                          done,
    output logic                          voiced,
    output logic [TAU_BITS-1:0]           pitch_tau,
    output logic [FRAC_BITS+TAU_BITS-1:0] pitch_val
`ifdef CMNDF_STREAM_EN
    ,
    output logic                          cmndf_valid,
    output logic [TAU_BITS-1:0]           cmndf_tau,
    output logic [FRAC_BITS+TAU_BITS-1:0] cmndf_out
`endif
);

    localparam int QW    = FRAC_BITS + TAU_BITS;
    localparam int SUM_W = DATA_WIDTH + TAU_BITS;
    localparam int DVD_W = SUM_W + FRAC_BITS;
    localparam int CNT_W = (QW > 1) ? $clog2(QW) : 1;

    localparam logic [QW-1:0]       ONE_C    = {{(QW-1){1'b0}}, 1'b1} << FRAC_BITS;
    localparam logic [QW-1:0]       THRESH_C = QW'(THRESHOLD);
    localparam logic [TAU_BITS-1:0] MIN_C    = TAU_BITS'(MIN_TAU);
    localparam logic [TAU_BITS-1:0] LAST_C   = TAU_BITS'(MAX_TAU - 1);
    localparam logic [CNT_W-1:0]    DIV_END  = CNT_W'(QW - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_DIV    = 3'd2,
        S_UPDATE = 3'd3,
        S_FIN    = 3'd4
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // datapath registers
    logic [SUM_W-1:0]    r_sum;
    logic [SUM_W-1:0]    r_rem;
    logic [QW-1:0]       r_quo;      // holds d'(tau) once the divide completes
    logic [TAU_BITS-1:0] r_tau;
    logic [CNT_W-1:0]    r_cnt;

    // search registers
    logic                r_found;
    logic                r_locked;
    logic [TAU_BITS-1:0] r_min_tau;
    logic [QW-1:0]       r_min_val;
    logic [TAU_BITS-1:0] r_best_tau;
    logic [QW-1:0]       r_best_val;

    // output registers
    logic                r_in_ready;
    logic                r_busy;
    logic                r_done;
    logic                r_voiced;
    logic [TAU_BITS-1:0] r_pitch_tau;
    logic [QW-1:0]       r_pitch_val;

    // next-state values
    logic [SUM_W-1:0]    w_sum_nxt;
    logic [SUM_W-1:0]    w_rem_nxt;
    logic [QW-1:0]       w_quo_nxt;
    logic [TAU_BITS-1:0] w_tau_nxt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                w_found_nxt;
    logic                w_locked_nxt;
    logic [TAU_BITS-1:0] w_min_tau_nxt;
    logic [QW-1:0]       w_min_val_nxt;
    logic [TAU_BITS-1:0] w_best_tau_nxt;
    logic [QW-1:0]       w_best_val_nxt;
    logic                w_in_ready_nxt;
    logic                w_busy_nxt;
    logic                w_done_nxt;

    // divider helpers
    logic [SUM_W-1:0]    w_prod;
    logic [DVD_W-1:0]    w_dvd;
    logic [SUM_W:0]      w_trial;
    logic                w_ge;
    logic [SUM_W-1:0]    w_rem_step;
    logic [QW-1:0]       w_quo_step;
    logic                w_last_tau;
    logic                w_div_end;
    logic                w_sum_zero;

    // The dividend is (d * tau) << FRAC_BITS.  Since d' <= tau, the quotient
    // fits in QW bits and the upper DATA_WIDTH dividend bits are already
    // smaller than the divisor, so they seed the partial remainder directly.
    assign w_prod     = SUM_W'(d_in) * SUM_W'(r_tau);
    assign w_dvd      = {w_prod, {FRAC_BITS{1'b0}}};
    assign w_trial    = {r_rem, r_quo[QW-1]};
    assign w_ge       = (w_trial >= {1'b0, r_sum});
    // The difference is below r_sum, so it is exact in SUM_W bits.
    assign w_rem_step = w_ge ? (w_trial[SUM_W-1:0] - r_sum) : w_trial[SUM_W-1:0];
    assign w_quo_step = {r_quo[QW-2:0], w_ge};
    assign w_last_tau = (r_tau == LAST_C);
    assign w_div_end  = (r_cnt == DIV_END);
    assign w_sum_zero = (r_sum == {SUM_W{1'b0}});

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_LOAD;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_LOAD: begin
                if (!in_valid) begin
                    w_state_nxt = S_LOAD;
                end else if (r_tau == {TAU_BITS{1'b0}}) begin
                    w_state_nxt = S_UPDATE;
                end else begin
                    w_state_nxt = S_DIV;
                end
            end
            S_DIV: begin
                if (w_sum_zero || w_div_end) begin
                    w_state_nxt = S_UPDATE;
                end else begin
                    w_state_nxt = S_DIV;
                end
            end
            S_UPDATE: begin
                if (w_last_tau) begin
                    w_state_nxt = S_FIN;
                end else begin
                    w_state_nxt = S_LOAD;
                end
            end
            S_FIN:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // FSM output decode; the decoded values are registered
    always_comb begin
        w_in_ready_nxt = 1'b0;
        w_busy_nxt     = 1'b0;
        w_done_nxt     = 1'b0;
        case (w_state_nxt)
            S_LOAD: begin
                w_in_ready_nxt = 1'b1;
                w_busy_nxt     = 1'b1;
            end
            S_DIV:    w_busy_nxt = 1'b1;
            S_UPDATE: w_busy_nxt = 1'b1;
            S_FIN:    w_done_nxt = 1'b1;
            S_IDLE:   w_busy_nxt = 1'b0;
            default:  w_busy_nxt = 1'b0;
        endcase
    end

    // Datapath next-state values: lag counter, running sum and restoring divider
    always_comb begin
        w_sum_nxt = r_sum;
        w_rem_nxt = r_rem;
        w_quo_nxt = r_quo;
        w_tau_nxt = r_tau;
        w_cnt_nxt = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_sum_nxt = {SUM_W{1'b0}};
                    w_tau_nxt = {TAU_BITS{1'b0}};
                    w_cnt_nxt = {CNT_W{1'b0}};
                end else begin
                    w_sum_nxt = r_sum;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    w_cnt_nxt = {CNT_W{1'b0}};
                    if (r_tau == {TAU_BITS{1'b0}}) begin
                        // d'(0) is defined as one; the sum starts at lag 1
                        w_quo_nxt = ONE_C;
                    end else begin
                        w_sum_nxt = r_sum + SUM_W'(d_in);
                        w_rem_nxt = {{TAU_BITS{1'b0}}, w_dvd[DVD_W-1:QW]};
                        w_quo_nxt = w_dvd[QW-1:0];
                    end
                end else begin
                    w_cnt_nxt = r_cnt;
                end
            end
            S_DIV: begin
                if (w_sum_zero) begin
                    // A zero running sum means every d(1..tau) was zero; d' = one
                    w_quo_nxt = ONE_C;
                end else begin
                    w_rem_nxt = w_rem_step;
                    w_quo_nxt = w_quo_step;
                    w_cnt_nxt = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            S_UPDATE: begin
                if (!w_last_tau) begin
                    w_tau_nxt = r_tau + {{(TAU_BITS-1){1'b0}}, 1'b1};
                end else begin
                    w_tau_nxt = r_tau;
                end
            end
            S_FIN:   w_tau_nxt = r_tau;
            default: w_tau_nxt = r_tau;
        endcase
    end

    // Threshold search: SEEK tracks the global minimum until the first
    // crossing, TRACK follows the descent, and the first non-decrease locks it
    always_comb begin
        w_found_nxt    = r_found;
        w_locked_nxt   = r_locked;
        w_min_tau_nxt  = r_min_tau;
        w_min_val_nxt  = r_min_val;
        w_best_tau_nxt = r_best_tau;
        w_best_val_nxt = r_best_val;
        if ((r_state == S_IDLE) && start) begin
            w_found_nxt    = 1'b0;
            w_locked_nxt   = 1'b0;
            w_min_tau_nxt  = {TAU_BITS{1'b0}};
            w_min_val_nxt  = {QW{1'b1}};   // above any reachable d'
            w_best_tau_nxt = {TAU_BITS{1'b0}};
            w_best_val_nxt = {QW{1'b0}};
        end else if ((r_state == S_UPDATE) && (r_tau >= MIN_C)) begin
            if (!r_found) begin
                if (r_quo < r_min_val) begin
                    w_min_tau_nxt = r_tau;
                    w_min_val_nxt = r_quo;
                end else begin
                    w_min_val_nxt = r_min_val;
                end
                if (r_quo < THRESH_C) begin
                    w_found_nxt    = 1'b1;
                    w_best_tau_nxt = r_tau;
                    w_best_val_nxt = r_quo;
                end else begin
                    w_found_nxt = 1'b0;
                end
            end else if (!r_locked) begin
                if (r_quo < r_best_val) begin
                    w_best_tau_nxt = r_tau;
                    w_best_val_nxt = r_quo;
                end else begin
                    w_locked_nxt = 1'b1;
                end
            end else begin
                w_locked_nxt = r_locked;
            end
        end else begin
            w_found_nxt = r_found;
        end
    end

    // Datapath and search registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sum      <= {SUM_W{1'b0}};
            r_rem      <= {SUM_W{1'b0}};
            r_quo      <= {QW{1'b0}};
            r_tau      <= {TAU_BITS{1'b0}};
            r_cnt      <= {CNT_W{1'b0}};
            r_found    <= 1'b0;
            r_locked   <= 1'b0;
            r_min_tau  <= {TAU_BITS{1'b0}};
            r_min_val  <= {QW{1'b0}};
            r_best_tau <= {TAU_BITS{1'b0}};
            r_best_val <= {QW{1'b0}};
        end else begin
            r_sum      <= w_sum_nxt;
            r_rem      <= w_rem_nxt;
            r_quo      <= w_quo_nxt;
            r_tau      <= w_tau_nxt;
            r_cnt      <= w_cnt_nxt;
            r_found    <= w_found_nxt;
            r_locked   <= w_locked_nxt;
            r_min_tau  <= w_min_tau_nxt;
            r_min_val  <= w_min_val_nxt;
            r_best_tau <= w_best_tau_nxt;
            r_best_val <= w_best_val_nxt;
        end
    end

    // Handshake, status and result registers; the result is captured on the
    // edge that enters FIN, so it appears together with done
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_voiced    <= 1'b0;
            r_pitch_tau <= {TAU_BITS{1'b0}};
            r_pitch_val <= {QW{1'b0}};
        end else begin
            r_in_ready <= w_in_ready_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            if (w_done_nxt) begin
                r_voiced    <= w_found_nxt;
                r_pitch_tau <= w_found_nxt ? w_best_tau_nxt : w_min_tau_nxt;
                r_pitch_val <= w_found_nxt ? w_best_val_nxt : w_min_val_nxt;
            end else begin
                r_voiced    <= r_voiced;
                r_pitch_tau <= r_pitch_tau;
                r_pitch_val <= r_pitch_val;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign busy      = r_busy;
    assign done      = r_done;
    assign voiced    = r_voiced;
    assign pitch_tau = r_pitch_tau;
    assign pitch_val = r_pitch_val;

`ifdef CMNDF_STREAM_EN
    logic                r_cmndf_valid;
    logic [TAU_BITS-1:0] r_cmndf_tau;
    logic [QW-1:0]       r_cmndf_out;

    // Stream strobe; it is registered so that it is high during UPDATE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cmndf_valid <= 1'b0;
            r_cmndf_tau   <= {TAU_BITS{1'b0}};
            r_cmndf_out   <= {QW{1'b0}};
        end else if (w_state_nxt == S_UPDATE) begin
            r_cmndf_valid <= 1'b1;
            r_cmndf_tau   <= r_tau;
            r_cmndf_out   <= w_quo_nxt;
        end else begin
            r_cmndf_valid <= 1'b0;
            r_cmndf_tau   <= r_cmndf_tau;
            r_cmndf_out   <= r_cmndf_out;
        end
    end

    assign cmndf_valid = r_cmndf_valid;
    assign cmndf_tau   = r_cmndf_tau;
    assign cmndf_out   = r_cmndf_out;
`endif

endmodule

// File: tb/tb_cmndf_pitch_module.sv
// -----------------------------------------------------------------------------
// Self-checking bench for cmndf_pitch_module.
// A table of frames, each with its expected pitch result, is applied in a
// loop.  The expected result is pushed to a scoreboard at start and popped
// when done pulses.  Hand-written sequences cover a start pulse while busy
// and a reset that aborts a frame.  When CMNDF_STREAM_EN is defined, each
// streamed d'(tau) is also compared with a numeric model.
// -----------------------------------------------------------------------------
module tb_cmndf_pitch_module;

    localparam int DW      = 32;
    localparam int FB      = 16;
    localparam int MT      = 40;
    localparam int TBITS   = 6;
    localparam int QW      = FB + TBITS;
    localparam int MIN_TAU = 2;
    localparam longint ONE = 64'd65536;
    localparam longint THR = 64'd6554;
    localparam int LAG_CYC = 1 + QW + 1;

    logic              clk;
    logic              reset;
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [DW-1:0]     d_in;
    logic              busy;
    logic              done;
    logic              voiced;
    logic [TBITS-1:0]  pitch_tau;
    logic [QW-1:0]     pitch_val;
`ifdef CMNDF_STREAM_EN
    logic              cmndf_valid;
    logic [TBITS-1:0]  cmndf_tau;
    logic [QW-1:0]     cmndf_out;
`endif

    cmndf_pitch_module dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .d_in      (d_in),
        .busy      (busy),
        .done      (done),
        .voiced    (voiced),
        .pitch_tau (pitch_tau),
        .pitch_val (pitch_val)
`ifdef CMNDF_STREAM_EN
        ,
        .cmndf_valid (cmndf_valid),
        .cmndf_tau   (cmndf_tau),
        .cmndf_out   (cmndf_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic   v;
        int     t;
        longint val;
    } res_t;

    typedef struct {
        int     kind;
        logic   exp_voiced;
        int     exp_tau;
        longint exp_val;
        logic   use_model;
        logic   chk_time;
    } vec_t;

    int     n_tests = 0;
    int     n_fail  = 0;
    longint fd [MT];
    res_t   sb_q [$];
    int     rdy_cnt;
    logic   done_seen;
    int     done_cyc;
    int     acc_cyc [MT];

`ifdef CMNDF_STREAM_EN
    typedef struct {
        int     t;
        longint v;
    } st_t;
    st_t st_q [$];
`endif

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Frame generators
    task automatic fill(input int kind);
        for (int t = 0; t < MT; t++) begin
            case (kind)
                0: fd[t] = (t == 0) ? 64'd0 : 64'd1000;
                1: fd[t] = 64'd0;
                2: fd[t] = (t == 0) ? 64'd0 : ((t == 4) ? 64'd1 : 64'd100);
                3: fd[t] = longint'($urandom_range(3000, 0));
                4: fd[t] = (t == 0) ? 64'd0 : ((t >= 36) ? longint'(40 - t) : 64'd1000);
                default: fd[t] = 64'd0;
            endcase
        end
    endtask

    // Reference model of normalisation and search over fd[]
    task automatic model(output res_t r);
        longint sum = 0;
        longint dp;
        longint min_v = 64'h7FFF_FFFF_FFFF_FFFF;
        int     min_t = 0;
        logic   found = 1'b0;
        logic   locked = 1'b0;
        int     best_t = 0;
        longint best_v = 0;
        for (int t = 0; t < MT; t++) begin
            if (t == 0) begin
                dp = ONE;
            end else begin
                sum = sum + fd[t];
                dp  = (sum == 0) ? ONE : (fd[t] * t * ONE) / sum;
            end
`ifdef CMNDF_STREAM_EN
            st_q.push_back('{t, dp});
`endif
            if (t >= MIN_TAU) begin
                if (!found) begin
                    if (dp < min_v) begin min_v = dp; min_t = t; end
                    if (dp < THR) begin found = 1'b1; best_t = t; best_v = dp; end
                end else if (!locked) begin
                    if (dp < best_v) begin best_t = t; best_v = dp; end
                    else locked = 1'b1;
                end
            end
        end
        r.v   = found;
        r.t   = found ? best_t : min_t;
        r.val = found ? best_v : min_v;
    endtask

    // Advance one clock and observe at the following falling edge
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        if (in_ready) rdy_cnt++;
        if (done) begin
            done_seen = 1'b1;
            done_cyc  = cyc;
        end
`ifdef CMNDF_STREAM_EN
        if (cmndf_valid) begin
            if (st_q.size() == 0) begin
                check("stream_extra_strobe", 1, 0);
            end else begin
                st_t e;
                e = st_q.pop_front();
                check("stream_tau", longint'(cmndf_tau), longint'(e.t));
                check("stream_val", longint'(cmndf_out), e.v);
            end
        end
`endif
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_in_ready"},  longint'(in_ready),  0);
        check({tag, "_busy"},      longint'(busy),      0);
        check({tag, "_done"},      longint'(done),      0);
        check({tag, "_voiced"},    longint'(voiced),    0);
        check({tag, "_pitch_tau"}, longint'(pitch_tau), 0);
        check({tag, "_pitch_val"}, longint'(pitch_val), 0);
    endtask

    // Drives one frame from fd[] with in_valid held high throughout.
    // abort_tau >= 0: reset is pulled low in DIV after that lag is accepted.
    // restart_tau >= 0: a start pulse is issued while that lag is pending.
    task automatic run_frame(input res_t exp, input int abort_tau,
                             input int restart_tau, input logic chk_time);
        int   t = 0;
        int   guard = 0;
        int   bad = 0;
        logic restarted = 1'b0;
        res_t got;
        rdy_cnt   = 0;
        done_seen = 1'b0;
        sb_q.push_back(exp);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", longint'(busy), 1);
        while (t < MT && guard < 5000) begin
            in_valid = 1'b1;
            d_in     = DW'(fd[t]);
            if (in_ready) begin
                tick();
                acc_cyc[t] = cyc;
                t++;
                if (abort_tau >= 0 && t == abort_tau + 1) begin
                    tick(); tick(); tick();
                    in_valid = 1'b0;
                    #2 reset = 1'b0;
                    #1 check_outputs_zero("abort");
                    void'(sb_q.pop_back());
`ifdef CMNDF_STREAM_EN
                    st_q.delete();
`endif
                    done_seen = 1'b0;
                    repeat (30) tick();
                    check("abort_no_done", longint'(done_seen), 0);
                    reset = 1'b1;
                    tick();
                    return;
                end
            end else begin
                if (restart_tau == t && !restarted) begin
                    start     = 1'b1;
                    restarted = 1'b1;
                end
                tick();
                start = 1'b0;
                if (restarted && restart_tau == t) begin
                    check("busy_after_restart", longint'(busy), 1);
                end
            end
            guard++;
        end
        in_valid = 1'b0;
        d_in     = '0;
        check("lags_accepted", longint'(t), MT);
        check("early_done", longint'(done_seen), 0);
        guard = 0;
        while (!done_seen && guard < 200) begin
            tick();
            guard++;
        end
        check("done_seen", longint'(done_seen), 1);
        if (done_seen) begin
            got = sb_q.pop_front();
            check("voiced",    longint'(voiced),    longint'(got.v));
            check("pitch_tau", longint'(pitch_tau), longint'(got.t));
            check("pitch_val", longint'(pitch_val), got.val);
            check("busy_at_done", longint'(busy), 0);
            check("ready_cycles", longint'(rdy_cnt), MT);
            if (chk_time) begin
                for (int k = 2; k < MT; k++) begin
                    if (acc_cyc[k] - acc_cyc[k-1] != LAG_CYC) bad++;
                end
                check("lag_spacing_bad", longint'(bad), 0);
                check("done_latency", longint'(done_cyc - acc_cyc[MT-1]), longint'(QW + 1));
            end
            tick(); tick(); tick();
            check("done_one_cycle", longint'(done), 0);
            check("hold_voiced",    longint'(voiced),    longint'(got.v));
            check("hold_pitch_tau", longint'(pitch_tau), longint'(got.t));
            check("hold_pitch_val", longint'(pitch_val), got.val);
        end
    endtask

    initial begin
        vec_t vecs [8];
        res_t exp;
        res_t mres;
        res_t dip;

        reset    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        d_in     = '0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        reset = 1'b1;
        @(negedge clk);

        vecs[0] = '{0, 1'b0, 2,  64'd65536, 1'b0, 1'b1};
        vecs[1] = '{0, 1'b0, 2,  64'd65536, 1'b0, 1'b1};
        vecs[2] = '{0, 1'b0, 2,  64'd65536, 1'b0, 1'b1};
        vecs[3] = '{0, 1'b0, 2,  64'd65536, 1'b0, 1'b1};
        vecs[4] = '{1, 1'b0, 2,  64'd65536, 1'b0, 1'b0};
        vecs[5] = '{2, 1'b1, 4,  64'd870,   1'b0, 1'b1};
        vecs[6] = '{4, 1'b1, 39, 64'd73,    1'b0, 1'b1};
        vecs[7] = '{3, 1'b0, 0,  64'd0,     1'b1, 1'b0};

        for (int i = 0; i < 8; i++) begin
            fill(vecs[i].kind);
            model(mres);
            if (vecs[i].use_model) begin
                exp = mres;
            end else begin
                exp.v   = vecs[i].exp_voiced;
                exp.t   = vecs[i].exp_tau;
                exp.val = vecs[i].exp_val;
            end
            run_frame(exp, -1, -1, vecs[i].chk_time);
        end

        dip.v   = 1'b1;
        dip.t   = 4;
        dip.val = 64'd870;

        // start pulse while busy must not restart the frame
        fill(2);
        model(mres);
        run_frame(dip, -1, 5, 1'b1);

        // reset mid-divide at tau 10, then a fresh dip frame
        fill(2);
        model(mres);
        run_frame(dip, 10, -1, 1'b0);
        fill(2);
        model(mres);
        run_frame(dip, -1, -1, 1'b1);

        check("scoreboard_empty", longint'(sb_q.size()), 0);
`ifdef CMNDF_STREAM_EN
        check("stream_queue_empty", longint'(st_q.size()), 0);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
